spmmio_bridge: RTL and testbench

- Bus-side front end of the soft-processor MMIO space.
- Accepts one CPU word transaction at a time and decodes the device index from the CPU address.
- Drives the shared peripheral strobe bus (adr/cs/sel/we/d) and returns the selected peripheral's read data with a single-cycle ack.
- Sits directly upstream of every spmmio_* peripheral; peripherals write on the clock edge ending their cs cycle, and their q is combinational on adr.

---
 rtl/spmmio_pkg.sv | 21 ++
 rtl/spmmio_dev_mux.sv | 40 ++++
 rtl/spmmio_bridge.sv | 172 +++++++++++++++++
 tb/tb_spmmio_bridge.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spmmio_pkg.sv
// Shared definitions for the soft-processor MMIO bridge and its helpers.
//
// Contents:
//   REG_ADR_W  - width of the peripheral register address
//   DATA_W     - width of the MMIO data path
//   WAIT_CNT_W - width of the bridge wait-state counter
//   state_t    - bridge FSM state encoding
package spmmio_pkg;

    localparam int REG_ADR_W  = 4;
    localparam int DATA_W     = 32;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/spmmio_dev_mux.sv
// Read-data selector for the MMIO bridge.
//
// Picks the 32-bit read-data slice of one peripheral out of the concatenated
// dev_q bus. Devices that are not present in DEV_PRESENT always return zero,
// so a floating or unused slice can never leak onto the CPU bus.
//
// Ports:
//   dev_idx - device index (numeric, device 0..NUM_DEV-1)
//   dev_q   - concatenated peripheral read data, device 0 in the top 32 bits
//   q       - selected read data
//
// Bit numbering: the documentation numbers buses MSB-first, so "device i at
// [32*i : 32*i+31]" means device 0 occupies the most significant word.
module spmmio_dev_mux
    import spmmio_pkg::*;
#(
    parameter int                         DEV_BITS    = 2,
    parameter logic [(2**DEV_BITS)-1:0]   DEV_PRESENT = '1
) (
    input  logic [DEV_BITS-1:0]                dev_idx,
    input  logic [DATA_W*(2**DEV_BITS)-1:0]    dev_q,
    output logic [DATA_W-1:0]                  q
);

    localparam int NUM_DEV = 2**DEV_BITS;

    logic [DATA_W-1:0] slice [NUM_DEV];

    // Device gi lives in the gi-th word counted from the MSB end.
    generate
        for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_slice
            assign slice[gi] = DEV_PRESENT[gi]
                             ? dev_q[DATA_W*(NUM_DEV-1-gi) +: DATA_W]
                             : '0;
        end
    endgenerate

    assign q = slice[dev_idx];

endmodule

// File: rtl/spmmio_bridge.sv
// Bus-side front end of the soft-processor MMIO space.
//
// Accepts one CPU word transaction at a time, decodes the device index from
// the top bits of cpu_adr, strobes the selected peripheral for exactly one
// cycle, optionally waits WAIT_CYCLES extra cycles, then captures read data
// and returns a single-cycle cpu_ack.
//
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   cpu_adr             - {device index, 4-bit register} word address
//   cpu_req             - level request, sampled only in IDLE
//   cpu_we/sel/d        - write flag, byte enables, write data
//   cpu_q/cpu_ack       - read data (valid with ack), one-cycle completion
//   adr/cs/sel/we/d     - shared peripheral strobe bus; cs is one-hot
//   dev_q               - concatenated peripheral read data
//
// Bit numbering: buses are documented MSB-first. cs "bit i" (device i) is
// therefore vector bit NUM_DEV-1-i, so device 0 drives the MSB of cs. The
// device index is the MSB field of cpu_adr, the register the low 4 bits.
module spmmio_bridge
    import spmmio_pkg::*;
#(
    parameter int                         DEV_BITS    = 2,
    parameter int                         WAIT_CYCLES = 0,
    parameter logic [(2**DEV_BITS)-1:0]   DEV_PRESENT = '1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [DEV_BITS+REG_ADR_W-1:0]       cpu_adr,
    input  logic                                cpu_req,
    input  logic                                cpu_we,
    input  logic [3:0]                          cpu_sel,
    input  logic [DATA_W-1:0]                   cpu_d,
    output logic [DATA_W-1:0]                   cpu_q,
    output logic                                cpu_ack,
    output logic [REG_ADR_W-1:0]                adr,
    output logic [(2**DEV_BITS)-1:0]            cs,
    output logic [3:0]                          sel,
    output logic                                we,
    output logic [DATA_W-1:0]                   d,
    input  logic [DATA_W*(2**DEV_BITS)-1:0]     dev_q
);

    localparam int NUM_DEV = 2**DEV_BITS;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t                 state_reg, state_next;
    logic [DEV_BITS-1:0]    dev_reg,   dev_next;
    logic [WAIT_CNT_W-1:0]  cnt_reg,   cnt_next;
    logic [DATA_W-1:0]      q_reg,     q_next;
    logic                   ack_reg,   ack_next;
    logic [REG_ADR_W-1:0]   adr_reg,   adr_next;
    logic [NUM_DEV-1:0]     cs_reg,    cs_next;
    logic [3:0]             sel_reg,   sel_next;
    logic                   we_reg,    we_next;
    logic [DATA_W-1:0]      d_reg,     d_next;

    logic [DEV_BITS-1:0]    dev_in;
    logic [NUM_DEV-1:0]     dev_onehot;
    logic [DATA_W-1:0]      mux_q;
    logic [DATA_W-1:0]      capture;

    assign dev_in = cpu_adr[DEV_BITS+REG_ADR_W-1 -: DEV_BITS];

    // One-hot select for the incoming index; absent devices never strobe.
    generate
        for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_onehot
            assign dev_onehot[NUM_DEV-1-gi] =
                (dev_in == DEV_BITS'(gi)) && DEV_PRESENT[gi];
        end
    endgenerate

    spmmio_dev_mux #(
        .DEV_BITS    (DEV_BITS),
        .DEV_PRESENT (DEV_PRESENT)
    ) u_dev_mux (
        .dev_idx (dev_reg),
        .dev_q   (dev_q),
        .q       (mux_q)
    );

    // Writes return zero; the mux already zeroes absent devices.
    assign capture = we_reg ? '0 : mux_q;

    always_comb begin
        state_next = state_reg;
        dev_next   = dev_reg;
        cnt_next   = cnt_reg;
        q_next     = q_reg;
        ack_next   = 1'b0;
        adr_next   = adr_reg;
        cs_next    = '0;
        sel_next   = sel_reg;
        we_next    = we_reg;
        d_next     = d_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cpu_req) begin
                    adr_next   = cpu_adr[REG_ADR_W-1:0];
                    sel_next   = cpu_sel;
                    we_next    = cpu_we;
                    d_next     = cpu_d;
                    dev_next   = dev_in;
                    cs_next    = dev_onehot;
                    state_next = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (WAIT_CYCLES == 0) begin
                    q_next     = capture;
                    ack_next   = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    cnt_next   = WAIT_LOAD;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_reg == '0) begin
                    q_next     = capture;
                    ack_next   = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            dev_reg   <= '0;
            cnt_reg   <= '0;
            q_reg     <= '0;
            ack_reg   <= 1'b0;
            adr_reg   <= '0;
            cs_reg    <= '0;
            sel_reg   <= '0;
            we_reg    <= 1'b0;
            d_reg     <= '0;
        end else begin
            state_reg <= state_next;
            dev_reg   <= dev_next;
            cnt_reg   <= cnt_next;
            q_reg     <= q_next;
            ack_reg   <= ack_next;
            adr_reg   <= adr_next;
            cs_reg    <= cs_next;
            sel_reg   <= sel_next;
            we_reg    <= we_next;
            d_reg     <= d_next;
        end
    end

    assign cpu_q   = q_reg;
    assign cpu_ack = ack_reg;
    assign adr     = adr_reg;
    assign cs      = cs_reg;
    assign sel     = sel_reg;
    assign we      = we_reg;
    assign d       = d_reg;

endmodule

// File: tb/tb_spmmio_bridge.sv
// Bench for spmmio_bridge: three instances (defaults, WAIT_CYCLES=3,
// DEV_PRESENT=4'b1011) sharing the CPU-side stimulus and dev_q bus.
module tb_spmmio_bridge;

    localparam int DB = 2;
    localparam int ND = 4;
    localparam int AW = DB + 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic            req_a, req_b, req_c;
    logic [AW-1:0]   cpu_adr;
    logic            cpu_we;
    logic [3:0]      cpu_sel;
    logic [31:0]     cpu_d;
    logic [32*ND-1:0] dev_q;

    logic [31:0] q_a, q_b, q_c, d_a, d_b, d_c;
    logic        ack_a, ack_b, ack_c, we_a, we_b, we_c;
    logic [3:0]  adr_a, adr_b, adr_c, sel_a, sel_b, sel_c;
    logic [ND-1:0] cs_a, cs_b, cs_c;

    spmmio_bridge #(.DEV_BITS(DB), .WAIT_CYCLES(0), .DEV_PRESENT(4'b1111)) u_a (
        .clk(clk), .reset(reset), .cpu_adr(cpu_adr), .cpu_req(req_a), .cpu_we(cpu_we),
        .cpu_sel(cpu_sel), .cpu_d(cpu_d), .cpu_q(q_a), .cpu_ack(ack_a), .adr(adr_a),
        .cs(cs_a), .sel(sel_a), .we(we_a), .d(d_a), .dev_q(dev_q));

    spmmio_bridge #(.DEV_BITS(DB), .WAIT_CYCLES(3), .DEV_PRESENT(4'b1111)) u_b (
        .clk(clk), .reset(reset), .cpu_adr(cpu_adr), .cpu_req(req_b), .cpu_we(cpu_we),
        .cpu_sel(cpu_sel), .cpu_d(cpu_d), .cpu_q(q_b), .cpu_ack(ack_b), .adr(adr_b),
        .cs(cs_b), .sel(sel_b), .we(we_b), .d(d_b), .dev_q(dev_q));

    spmmio_bridge #(.DEV_BITS(DB), .WAIT_CYCLES(0), .DEV_PRESENT(4'b1011)) u_c (
        .clk(clk), .reset(reset), .cpu_adr(cpu_adr), .cpu_req(req_c), .cpu_we(cpu_we),
        .cpu_sel(cpu_sel), .cpu_d(cpu_d), .cpu_q(q_c), .cpu_ack(ack_c), .adr(adr_c),
        .cs(cs_c), .sel(sel_c), .we(we_c), .d(d_c), .dev_q(dev_q));

    // Outputs of the instance currently under test.
    int          cur = 0;
    logic [31:0] o_q, o_d;
    logic        o_ack, o_we;
    logic [3:0]  o_adr, o_sel;
    logic [ND-1:0] o_cs;

    always_comb begin
        o_q = q_a; o_d = d_a; o_ack = ack_a; o_we = we_a; o_adr = adr_a; o_sel = sel_a; o_cs = cs_a;
        case (cur)
            1: begin o_q = q_b; o_d = d_b; o_ack = ack_b; o_we = we_b; o_adr = adr_b; o_sel = sel_b; o_cs = cs_b; end
            2: begin o_q = q_c; o_d = d_c; o_ack = ack_c; o_we = we_c; o_adr = adr_c; o_sel = sel_c; o_cs = cs_c; end
            default: ;
        endcase
    end

    int errors = 0;
    int checks = 0;
    logic [31:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_dev(input int i, input logic [31:0] v);
        dev_q[32*(ND-1-i) +: 32] = v;
    endtask

    task automatic set_req(input int inst, input logic v);
        case (inst)
            1: req_b = v;
            2: req_c = v;
            default: req_a = v;
        endcase
    endtask

    // One transaction: drive, sample the strobe cycle, wait for ack (bounded),
    // pop the scoreboard, then confirm ack dropped and cpu_q holds.
    task automatic txn(input int inst, input string name,
                       input logic [AW-1:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] dd, input logic [3:0] exp_adr,
                       input logic [ND-1:0] exp_cs, input logic [31:0] exp_q,
                       input int exp_end, input int chg_k, input int chg_dev,
                       input logic [31:0] chg_val);
        int cs_cycles;
        int ack_end;
        logic [31:0] exp_pop;
        cur = inst;
        sb.push_back(exp_q);
        cs_cycles = 0;
        ack_end = -1;
        @(negedge clk);
        cpu_adr = a; cpu_we = w; cpu_sel = s; cpu_d = dd;
        set_req(inst, 1'b1);
        @(posedge clk);
        #1 set_req(inst, 1'b0);
        @(negedge clk);
        if (o_cs != 0) cs_cycles++;
        chk({name, " strobe cs"},  32'(o_cs),  32'(exp_cs));
        chk({name, " strobe adr"}, 32'(o_adr), 32'(exp_adr));
        chk({name, " strobe we"},  32'(o_we),  32'(w));
        chk({name, " strobe sel"}, 32'(o_sel), 32'(s));
        chk({name, " strobe d"},   o_d, dd);
        chk({name, " no early ack"}, 32'(o_ack), 32'd0);
        for (int k = 1; k <= 20 && ack_end < 0; k++) begin
            @(negedge clk);
            if (k == chg_k) set_dev(chg_dev, chg_val);
            if (o_cs != 0) cs_cycles++;
            if (o_ack) ack_end = k + 1;
        end
        if (ack_end < 0) begin
            chk({name, " ack timeout"}, 32'd0, 32'd1);
        end else begin
            exp_pop = sb.pop_front();
            chk({name, " ack q"}, o_q, exp_pop);
            chk({name, " ack latency"}, 32'(ack_end), 32'(exp_end));
        end
        chk({name, " cs cycles"}, 32'(cs_cycles), (exp_cs != 0) ? 32'd1 : 32'd0);
        @(negedge clk);
        chk({name, " ack drop"}, 32'(o_ack), 32'd0);
        chk({name, " q hold"}, o_q, exp_q);
        $display("txn %s: inst=%0d adr=%h we=%0d q=%h ack_end=%0d", name, inst, a, w, o_q, ack_end);
    endtask

    typedef struct {
        logic [AW-1:0] adr;
        logic          we;
        logic [3:0]    sel;
        logic [31:0]   d;
        logic [3:0]    exp_adr;
        logic [ND-1:0] exp_cs;
        logic [31:0]   exp_q;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cs_n;
        int ack_n;
        logic [31:0] p;

        vecs[0] = '{6'h00, 1'b1, 4'b0001, 32'h00000003, 4'h0, 4'b1000, 32'h00000000};
        vecs[1] = '{6'h25, 1'b0, 4'b1111, 32'h00000000, 4'h5, 4'b0010, 32'hDEADBEEF};
        vecs[2] = '{6'h0F, 1'b0, 4'b1100, 32'h12345678, 4'hF, 4'b1000, 32'h01234567};
        vecs[3] = '{6'h1A, 1'b0, 4'b0011, 32'h0, 4'hA, 4'b0100, 32'h89ABCDEF};
        vecs[4] = '{6'h33, 1'b0, 4'b1111, 32'h0, 4'h3, 4'b0001, 32'h5A5AA5A5};
        vecs[5] = '{6'h3C, 1'b1, 4'b1010, 32'hCAFEF00D, 4'hC, 4'b0001, 32'h00000000};

        reset = 1'b1;
        req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        cpu_adr = '0; cpu_we = 1'b0; cpu_sel = '0; cpu_d = '0;
        dev_q = '0;
        set_dev(0, 32'h01234567);
        set_dev(1, 32'h89ABCDEF);
        set_dev(2, 32'hDEADBEEF);
        set_dev(3, 32'h5A5AA5A5);
        #1;
        chk("reset q",   q_a, 32'd0);
        chk("reset ack", 32'(ack_a), 32'd0);
        chk("reset cs",  32'(cs_a), 32'd0);
        chk("reset adr", 32'(adr_a), 32'd0);
        chk("reset d",   d_a, 32'd0);
        chk("reset b cs", 32'(cs_b), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++)
            txn(0, $sformatf("vec%0d", i), vecs[i].adr, vecs[i].we, vecs[i].sel, vecs[i].d,
                vecs[i].exp_adr, vecs[i].exp_cs, vecs[i].exp_q, 2, -1, 0, 32'h0);

        // Wait states: data changes after the strobe but before capture.
        set_dev(2, 32'h11111111);
        txn(1, "wait3", 6'h25, 1'b0, 4'hF, 32'h0, 4'h5, 4'b0010, 32'h22222222, 5, 2, 2, 32'h22222222);

        // Absent device: no strobe, zero data, normal latency.
        set_dev(2, 32'hDEADBEEF);
        txn(2, "absent2", 6'h25, 1'b0, 4'hF, 32'h0, 4'h5, 4'b0000, 32'h00000000, 2, -1, 0, 32'h0);
        txn(2, "present3", 6'h31, 1'b0, 4'hF, 32'h0, 4'h1, 4'b0001, 32'h5A5AA5A5, 2, -1, 0, 32'h0);

        // Back-to-back: req held for 9 sampling edges -> three transactions.
        cur = 0;
        repeat (3) sb.push_back(32'h89ABCDEF);
        cs_n = 0;
        ack_n = 0;
        @(negedge clk);
        cpu_adr = 6'h1A; cpu_we = 1'b0; cpu_sel = 4'hF;
        req_a = 1'b1;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1 if (e == 8) req_a = 1'b0;
            @(negedge clk);
            if (o_cs != 0) begin
                chk("b2b cs value", 32'(o_cs), 32'(4'b0100));
                chk("b2b cs edge", 32'(e), 32'(3 * cs_n));
                cs_n++;
            end
            if (o_ack) begin
                chk("b2b ack edge", 32'(e), 32'(3 * ack_n + 1));
                if (sb.size() > 0) begin
                    p = sb.pop_front();
                    chk("b2b ack q", o_q, p);
                end else begin
                    chk("b2b extra ack", 32'd1, 32'd0);
                end
                ack_n++;
            end
        end
        chk("b2b cs count", 32'(cs_n), 32'd3);
        chk("b2b ack count", 32'(ack_n), 32'd3);
        $display("txn b2b: strobes=%0d acks=%0d", cs_n, ack_n);
        sb.delete();

        // Reset in the middle of the strobe cycle.
        @(negedge clk);
        cpu_adr = 6'h37; cpu_we = 1'b1; cpu_sel = 4'hF; cpu_d = 32'hA5A55A5A;
        req_a = 1'b1;
        @(posedge clk);
        #3;
        chk("rst pre cs", 32'(cs_a), 32'(4'b0001));
        reset = 1'b1;
        #1;
        chk("rst cs",  32'(cs_a),  32'd0);
        chk("rst ack", 32'(ack_a), 32'd0);
        chk("rst q",   q_a, 32'd0);
        chk("rst adr", 32'(adr_a), 32'd0);
        chk("rst sel", 32'(sel_a), 32'd0);
        chk("rst we",  32'(we_a),  32'd0);
        chk("rst d",   d_a, 32'd0);
        req_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst no ack", 32'(ack_a), 32'd0);
        end
        reset = 1'b0;
        $display("txn reset: discarded mid-strobe");
        txn(0, "post_rst", 6'h0F, 1'b0, 4'hF, 32'h0, 4'hF, 4'b1000, 32'h01234567, 2, -1, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
